multi_way_traffic_controller: RTL and testbench

//  Parametrised, timed traffic-light controller for N_DIR approach groups.
//  - Successor of the two-way NS/EW controller: per-direction red/yellow/green

---
 rtl/tlc_pkg.sv | 16 +
 rtl/tlc_rr_arbiter.sv | 31 +++
 rtl/multi_way_traffic_controller.sv | 110 +++++++++++
 tb/tb_multi_way_traffic_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-way traffic-light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_EMERG  = 2'd3
  } phase_t;

  // Direction index width; at least one bit even for two directions.
  function automatic int unsigned dir_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin picker: first requesting direction after last,
// with last itself checked last; falls back to last+1 when nothing requests.
module tlc_rr_arbiter
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR = 4
) (
  input  logic [N_DIR-1:0]        req,
  input  logic [dir_w(N_DIR)-1:0] last,
  output logic [dir_w(N_DIR)-1:0] next
);

  localparam int unsigned DIR_W = dir_w(N_DIR);

  logic [31:0] idx;
  logic        found;

  always_comb begin
    next  = DIR_W'((32'(last) + 32'd1) % N_DIR);
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_DIR; i++) begin
      idx = (32'(last) + i) % N_DIR;
      if (!found && req[idx[DIR_W-1:0]]) begin
        next  = DIR_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// Timed N-direction traffic-light controller: demand-driven round-robin
// greens, yellow and all-red clearance, and an emergency all-red override.
module multi_way_traffic_controller
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR     = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_DIR-1:0]        req,
  input  logic                    emergency,
  output logic [N_DIR-1:0]        green,
  output logic [N_DIR-1:0]        yellow,
  output logic [N_DIR-1:0]        red,
  output logic [dir_w(N_DIR)-1:0] active_dir,
  output logic [1:0]              phase
);

  localparam int unsigned DIR_W = dir_w(N_DIR);

  if (N_DIR < 2 || N_DIR > 8 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
      YELLOW_T < 1 || ALLRED_T < 1 || CNT_W < 1 || CNT_W > 31 ||
      (GREEN_MAX >> CNT_W) != 0 || (YELLOW_T >> CNT_W) != 0 ||
      (ALLRED_T >> CNT_W) != 0) begin : g_bad_params
    $error("multi_way_traffic_controller: illegal parameter combination");
  end

  phase_t             phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d, arb_next;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [N_DIR-1:0]   dir_onehot;
  logic               green_done;

  tlc_rr_arbiter #(.N_DIR(N_DIR)) u_arb (
    .req  (req),
    .last (dir_q),
    .next (arb_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_ALLRED;
      dir_q   <= DIR_W'(N_DIR - 1);
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  assign dir_onehot = N_DIR'(1) << dir_q;

  // Green ends at the hard maximum, or after the minimum once another direction waits.
  assign green_done = (timer_q == CNT_W'(GREEN_MAX - 1)) ||
                      ((timer_q >= CNT_W'(GREEN_MIN - 1)) && ((req & ~dir_onehot) != '0));

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    timer_d = timer_q + CNT_W'(1);
    if (emergency) begin
      phase_d = PH_EMERG;
      timer_d = '0;
    end else begin
      unique case (phase_q)
        PH_ALLRED: if (timer_q == CNT_W'(ALLRED_T - 1)) begin
          phase_d = PH_GREEN;
          dir_d   = arb_next;
          timer_d = '0;
        end
        PH_GREEN: if (green_done) begin
          phase_d = PH_YELLOW;
          timer_d = '0;
        end
        PH_YELLOW: if (timer_q == CNT_W'(YELLOW_T - 1)) begin
          phase_d = PH_ALLRED;
          timer_d = '0;
        end
        PH_EMERG: begin
          phase_d = PH_ALLRED;
          timer_d = '0;
        end
        default: begin
          phase_d = PH_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore lamp decode straight from the state registers.
  always_comb begin
    green  = (phase_q == PH_GREEN)  ? dir_onehot : '0;
    yellow = (phase_q == PH_YELLOW) ? dir_onehot : '0;
    red    = ~(green | yellow);
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

  lamp_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0(green | yellow) && ((green & yellow) == '0));

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Scoreboard bench: expected lamp/phase/direction per cycle is queued with
// the stimulus and compared one cycle at a time after each rising edge.
module tb_multi_way_traffic_controller;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] dir;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       emergency;
  logic [3:0] req4;
  logic [1:0] req2;
  logic [3:0] green4, yellow4, red4;
  logic [1:0] dir4, phase4;
  logic [1:0] green2, yellow2, red2, phase2;
  logic       dir2;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_way_traffic_controller #(
    .N_DIR(4), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req4), .emergency(emergency),
    .green(green4), .yellow(yellow4), .red(red4), .active_dir(dir4), .phase(phase4)
  );

  multi_way_traffic_controller #(
    .N_DIR(2), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
  ) dut2 (
    .clk(clk), .rst(rst), .req(req2), .emergency(emergency),
    .green(green2), .yellow(yellow2), .red(red2), .active_dir(dir2), .phase(phase2)
  );

  function automatic string fmt(input exp_t e);
    return $sformatf("ph=%0d dir=%0d g=%b y=%b r=%b", e.ph, e.dir, e.g, e.y, e.r);
  endfunction

  task automatic push_exp(input logic [1:0] ph, input logic [1:0] dir, input int n, input bit use2);
    exp_t e;
    logic [3:0] mask;
    mask  = use2 ? 4'b0011 : 4'b1111;
    e.ph  = ph;
    e.dir = dir;
    e.g   = (ph == 2'd1) ? ((4'b0001 << dir) & mask) : 4'b0000;
    e.y   = (ph == 2'd2) ? ((4'b0001 << dir) & mask) : 4'b0000;
    e.r   = ~(e.g | e.y) & mask;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic observe(input bit use2, output exp_t o);
    @(posedge clk);
    #1;
    if (use2) begin
      o.ph = phase2; o.dir = {1'b0, dir2};
      o.g = {2'b00, green2}; o.y = {2'b00, yellow2}; o.r = {2'b00, red2};
    end else begin
      o.ph = phase4; o.dir = dir4; o.g = green4; o.y = yellow4; o.r = red4;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; emergency = 1'b0; req4 = '0; req2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, e;
    rst = 1'b1; emergency = 1'b0; req4 = '0; req2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({phase4, dir4, green4, yellow4, red4} !== {2'd0, 2'd3, 4'b0000, 4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL reset4: got ph=%0d dir=%0d g=%b y=%b r=%b, want ph=0 dir=3 g=0000 y=0000 r=1111",
               phase4, dir4, green4, yellow4, red4);
    end
    checks++;
    if ({phase2, dir2, green2, yellow2, red2} !== {2'd0, 1'b1, 2'b00, 2'b00, 2'b11}) begin
      errors++;
      $display("FAIL reset2: got ph=%0d dir=%0d g=%b y=%b r=%b, want ph=0 dir=1 g=00 y=00 r=11",
               phase2, dir2, green2, yellow2, red2);
    end
    rst = 1'b0;
    push_exp(2'd1, 2'd0, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL first_green: got %s, want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_rotation();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    for (int d = 0; d < 4; d++) begin
      push_exp(2'd1, 2'(d), 6, 0);
      push_exp(2'd2, 2'(d), 2, 0);
      push_exp(2'd0, 2'(d), 1, 0);
    end
    push_exp(2'd1, 2'd0, 6, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL rotation cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_early_switch();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    push_exp(2'd1, 2'd0, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL early_start: got %s, want %s", fmt(o), fmt(e)); end
    end
    req4 = 4'b0100;
    push_exp(2'd1, 2'd0, 2, 0);
    push_exp(2'd2, 2'd0, 2, 0);
    push_exp(2'd0, 2'd0, 1, 0);
    push_exp(2'd1, 2'd2, 6, 0);
    push_exp(2'd2, 2'd2, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL early_switch cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
    req4 = '0;
  endtask

  task automatic test_self_demand();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    req4 = 4'b0001;
    push_exp(2'd1, 2'd0, 6, 0);
    push_exp(2'd2, 2'd0, 2, 0);
    push_exp(2'd0, 2'd0, 1, 0);
    push_exp(2'd1, 2'd0, 2, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL self_demand cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
    req4 = '0;
  endtask

  task automatic test_emergency();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    push_exp(2'd1, 2'd0, 6, 0);
    push_exp(2'd2, 2'd0, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL emerg_lead: got %s, want %s", fmt(o), fmt(e)); end
    end
    emergency = 1'b1;
    push_exp(2'd3, 2'd0, 5, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL emerg_hold cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
    emergency = 1'b0;
    push_exp(2'd0, 2'd0, 1, 0);
    push_exp(2'd1, 2'd1, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL emerg_exit: got %s, want %s", fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_mid_reset();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    push_exp(2'd1, 2'd0, 3, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_reset_lead: got %s, want %s", fmt(o), fmt(e)); end
    end
    rst = 1'b1;
    emergency = 1'b1;
    push_exp(2'd0, 2'd3, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_reset_state: got %s, want %s", fmt(o), fmt(e)); end
    end
    rst = 1'b0;
    emergency = 1'b0;
    push_exp(2'd1, 2'd0, 6, 0);
    push_exp(2'd2, 2'd0, 1, 0);
    while (q.size() > 0) begin
      observe(0, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL mid_reset_timer cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    int cyc = 0;
    apply_reset();
    req2 = 2'b11;
    push_exp(2'd1, 2'd0, 3, 1);
    push_exp(2'd2, 2'd0, 2, 1);
    push_exp(2'd0, 2'd0, 1, 1);
    push_exp(2'd1, 2'd1, 3, 1);
    push_exp(2'd2, 2'd1, 2, 1);
    push_exp(2'd0, 2'd1, 1, 1);
    push_exp(2'd1, 2'd0, 3, 1);
    push_exp(2'd2, 2'd0, 1, 1);
    while (q.size() > 0) begin
      observe(1, o); e = q.pop_front(); checks++; cyc++;
      if (o !== e) begin errors++; $display("FAIL two_way cyc %0d: got %s, want %s", cyc, fmt(o), fmt(e)); end
    end
    req2 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rotation();
    test_early_switch();
    test_self_demand();
    test_emergency();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
